// File: rtl/avmm_rw_responder.sv
// Avalon-MM responder modelling a fixed-latency, word-addressed on-chip memory with
// byte-enable writes, a backdoor preload/inspect port and saturating access counters.
module avmm_rw_responder #(
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              avmm_address,
    input  logic [DATA_W/8-1:0]      avmm_byteenable,
    input  logic                     avmm_read,
    output logic [DATA_W-1:0]        avmm_readdata,
    input  logic                     avmm_write,
    input  logic [DATA_W-1:0]        avmm_writedata,
    input  logic                     bd_we,
    input  logic [$clog2(DEPTH)-1:0] bd_addr,
    input  logic [DATA_W-1:0]        bd_wdata,
    output logic [DATA_W-1:0]        bd_rdata,
    output logic [31:0]              rd_count,
    output logic [31:0]              wr_count,
    output logic [15:0]              err_count
);
    localparam int unsigned BYTES      = DATA_W / 8;
    localparam int unsigned OFF_W      = $clog2(BYTES);
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [32:0] SPAN       = 33'(DEPTH) * 33'(BYTES);
    localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

    logic [31:0]       offset;
    logic              in_range;
    logic [AW-1:0]     word_idx;
    logic              wr_en;
    logic              rd_en;
    logic              err_en;
    logic              bd_en;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pipe_q [READ_LATENCY];
    logic [DATA_W-1:0] bd_rdata_q;
    logic [31:0]       rd_count_q, rd_count_d;
    logic [31:0]       wr_count_q, wr_count_d;
    logic [15:0]       err_count_q, err_count_d;

    // Address decode and request qualification
    always_comb begin
        offset   = avmm_address - BASE_ADDR;
        in_range = ({1'b0, offset} < SPAN) && ((offset & ALIGN_MASK) == 32'd0);
        word_idx = AW'(offset >> OFF_W);
        wr_en    = avmm_write && in_range;
        // A read alongside a write is illegal: it is never served, only flagged.
        rd_en    = avmm_read && !avmm_write && in_range;
        err_en   = (avmm_read && avmm_write) || ((avmm_read || avmm_write) && !in_range);
        bd_en    = bd_we && !(wr_en && (word_idx == bd_addr));
        rd_word  = rd_en ? mem[word_idx] : '0;
    end

    // Storage is deliberately not reset so preloaded contents survive a reset.
    always_ff @(posedge clock) begin
        if (bd_en) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (wr_en) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (avmm_byteenable[k]) begin
                    mem[word_idx][8*k +: 8] <= avmm_writedata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rd_word;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bd_rdata_q <= '0;
        end else begin
            bd_rdata_q <= mem[bd_addr];
        end
    end

    always_comb begin
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        if (rd_en && (rd_count_q != '1)) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (wr_en && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + 32'd1;
        end
        if (err_en && (err_count_q != '1)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign avmm_readdata = pipe_q[READ_LATENCY-1];
    assign bd_rdata      = bd_rdata_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_avmm_rw_responder.sv
// Bench for avmm_rw_responder: two instances (read latency 1 and 4) share one stimulus
// stream and are checked against a word-array memory model with a per-cycle result log.
`timescale 1ns/1ps
module tb_avmm_rw_responder;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned AW     = 10;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       av_addr;
    logic [BYTES-1:0]  av_be;
    logic              av_read;
    logic              av_write;
    logic [DATA_W-1:0] av_wdata;
    logic              bd_we;
    logic [AW-1:0]     bd_addr;
    logic [DATA_W-1:0] bd_wdata;
    logic [DATA_W-1:0] rdata1, rdata4, bdr1, bdr4;
    logic [31:0]       rdc1, rdc4, wrc1, wrc4;
    logic [15:0]       errc1, errc4;

    always #5 clock = ~clock;

    avmm_rw_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .avmm_address(av_addr), .avmm_byteenable(av_be),
        .avmm_read(av_read), .avmm_readdata(rdata1), .avmm_write(av_write),
        .avmm_writedata(av_wdata), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bdr1), .rd_count(rdc1), .wr_count(wrc1), .err_count(errc1)
    );

    avmm_rw_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(4)) dut4 (
        .clock(clock), .reset(reset), .avmm_address(av_addr), .avmm_byteenable(av_be),
        .avmm_read(av_read), .avmm_readdata(rdata4), .avmm_write(av_write),
        .avmm_writedata(av_wdata), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bdr4), .rd_count(rdc4), .wr_count(wrc4), .err_count(errc4)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: memory contents, one read result per clock since reset, counters.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] results [$];
    logic [DATA_W-1:0] ref_bd;
    int unsigned       ref_rd, ref_wr, ref_err;

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic bit ref_ok(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < DEPTH * BYTES) && (off % BYTES == 0);
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(int lat);
        if (results.size() < lat) return '0;
        return results[results.size() - lat];
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        logic [31:0] w;
        sel = $urandom_range(0, 9);
        w   = 32'($urandom_range(0, DEPTH - 1));
        if (sel < 6) return BASE + w * BYTES;
        if (sel == 6) return BASE + w * BYTES + 32'($urandom_range(1, BYTES - 1));
        if (sel == 7) return BASE + DEPTH * BYTES + 32'($urandom_range(0, 4095));
        if (sel == 8) return BASE - BYTES;
        return $urandom();
    endfunction

    task automatic idle();
        av_read  = 1'b0;
        av_write = 1'b0;
        bd_we    = 1'b0;
    endtask

    task automatic model_reset();
        results.delete();
        ref_rd  = 0;
        ref_wr  = 0;
        ref_err = 0;
        ref_bd  = '0;
    endtask

    // Advance one clock, apply the sampled request to the model, settle 1 ns past the edge.
    task automatic tick();
        logic [DATA_W-1:0] r;
        logic [31:0]       w;
        bit                ok;
        @(posedge clock);
        if (!reset) begin
            ok     = ref_ok(av_addr);
            w      = (av_addr - BASE) / BYTES;
            r      = '0;
            ref_bd = ref_mem[bd_addr];
            if (av_read && !av_write && ok) begin
                r = ref_mem[w];
                if (ref_rd != 32'hFFFF_FFFF) ref_rd++;
            end
            if ((av_read && av_write) || ((av_read || av_write) && !ok)) begin
                if (ref_err != 32'h0000_FFFF) ref_err++;
            end
            if (bd_we && !(av_write && ok && w[AW-1:0] == bd_addr)) ref_mem[bd_addr] = bd_wdata;
            if (av_write && ok) begin
                for (int k = 0; k < BYTES; k++)
                    if (av_be[k]) ref_mem[w][8*k +: 8] = av_wdata[8*k +: 8];
                if (ref_wr != 32'hFFFF_FFFF) ref_wr++;
            end
            results.push_back(r);
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        av_addr  = '0;
        av_be    = '0;
        av_wdata = '0;
        bd_addr  = '0;
        bd_wdata = '0;
        reset    = 1'b1;
        model_reset();
        repeat (3) tick();
        total++; if (rdata1 !== '0) begin bad++; $display("FAIL reset_rdata1 got=%h want=0", rdata1); end
        total++; if (rdata4 !== '0) begin bad++; $display("FAIL reset_rdata4 got=%h want=0", rdata4); end
        total++; if (bdr1 !== '0) begin bad++; $display("FAIL reset_bd_rdata got=%h want=0", bdr1); end
        total++; if ({rdc1, wrc1, errc1} !== '0) begin
            bad++; $display("FAIL reset_counters got rd=%0d wr=%0d err=%0d want 0", rdc1, wrc1, errc1);
        end
        reset = 1'b0;
        // Preload every word so no read ever sees uninitialised storage.
        for (int i = 0; i < DEPTH; i++) begin
            bd_we    = 1'b1;
            bd_addr  = AW'(i);
            bd_wdata = rand_word();
            tick();
        end
        idle();
        tick();
        total++; if ({rdc4, wrc4, errc4} !== '0) begin
            bad++; $display("FAIL preload_counters got rd=%0d wr=%0d err=%0d want 0", rdc4, wrc4, errc4);
        end
    endtask

    task automatic test_backdoor_read_seq();
        for (int i = 0; i < 4; i++) begin
            bd_we    = 1'b1;
            bd_addr  = AW'(i);
            bd_wdata = DATA_W'(i * 32'h1111);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            av_read = 1'b1;
            av_addr = 32'(i * BYTES);
            tick();
            total++; if (rdata1 !== DATA_W'(i * 32'h1111)) begin
                bad++; $display("FAIL seq_read%0d got=%h want=%h", i, rdata1, DATA_W'(i * 32'h1111));
            end
        end
        idle();
        tick();
        total++; if (rdata1 !== '0) begin bad++; $display("FAIL seq_idle got=%h want=0", rdata1); end
        total++; if (rdc1 !== 32'd4) begin bad++; $display("FAIL seq_rd_count got=%0d want=4", rdc1); end
    endtask

    task automatic test_byteenable();
        logic [DATA_W-1:0] want;
        want = {{(BYTES - 4){8'hFF}}, {4{8'hAA}}};
        bd_we    = 1'b1;
        bd_addr  = AW'(5);
        bd_wdata = '1;
        tick();
        idle();
        av_write = 1'b1;
        av_addr  = 32'h0000_00A0;
        av_be    = 32'h0000_000F;
        av_wdata = {BYTES{8'hAA}};
        tick();
        av_write = 1'b0;
        av_read  = 1'b1;
        tick();
        idle();
        total++; if (rdata1 !== want) begin bad++; $display("FAIL be_read got=%h want=%h", rdata1, want); end
        total++; if (wrc1 !== 32'd1) begin bad++; $display("FAIL be_wr_count got=%0d want=1", wrc1); end
        repeat (3) tick();
        total++; if (rdata4 !== want) begin bad++; $display("FAIL be_read_lat4 got=%h want=%h", rdata4, want); end
    endtask

    task automatic test_errors();
        int unsigned rd0, err0;
        rd0  = ref_rd;
        err0 = ref_err;
        av_read = 1'b1;
        av_addr = 32'h0000_8000;
        tick();
        total++; if (rdata1 !== '0) begin bad++; $display("FAIL err_range_data got=%h want=0", rdata1); end
        av_addr = 32'h0000_0021;
        tick();
        idle();
        total++; if (rdata1 !== '0) begin bad++; $display("FAIL err_align_data got=%h want=0", rdata1); end
        tick();
        total++; if (errc1 !== 16'(err0 + 2)) begin
            bad++; $display("FAIL err_count got=%0d want=%0d", errc1, err0 + 2);
        end
        total++; if (rdc1 !== rd0) begin bad++; $display("FAIL err_rd_count got=%0d want=%0d", rdc1, rd0); end
    endtask

    task automatic test_latency4();
        logic [DATA_W-1:0] word;
        word     = rand_word() | DATA_W'(1);
        bd_we    = 1'b1;
        bd_addr  = AW'(7);
        bd_wdata = word;
        tick();
        idle();
        av_read = 1'b1;
        av_addr = 32'(7 * BYTES);
        tick();
        av_read = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            total++; if (rdata4 !== ((k == 4) ? word : '0)) begin
                bad++; $display("FAIL lat4_cycle%0d got=%h want=%h", k, rdata4, (k == 4) ? word : '0);
            end
            tick();
        end
    endtask

    task automatic test_raw_illegal();
        int unsigned err0, wr0;
        av_be    = '1;
        av_write = 1'b1;
        av_addr  = 32'(2 * BYTES);
        av_wdata = DATA_W'(5);
        tick();
        av_write = 1'b0;
        av_read  = 1'b1;
        tick();
        total++; if (rdata1 !== DATA_W'(5)) begin bad++; $display("FAIL raw_read got=%h want=5", rdata1); end
        idle();
        tick();
        err0     = ref_err;
        wr0      = ref_wr;
        av_read  = 1'b1;
        av_write = 1'b1;
        av_wdata = DATA_W'(32'h77);
        tick();
        idle();
        bd_addr = AW'(2);
        total++; if (rdata1 !== '0) begin bad++; $display("FAIL rw_read_zero got=%h want=0", rdata1); end
        tick();
        total++; if (errc1 !== 16'(err0 + 1)) begin
            bad++; $display("FAIL rw_err_count got=%0d want=%0d", errc1, err0 + 1);
        end
        total++; if (wrc1 !== wr0 + 1) begin bad++; $display("FAIL rw_wr_count got=%0d want=%0d", wrc1, wr0 + 1); end
        total++; if (bdr1 !== DATA_W'(32'h77)) begin bad++; $display("FAIL rw_write_applied got=%h want=77", bdr1); end
        repeat (2) tick();
        total++; if (rdata4 !== '0) begin bad++; $display("FAIL rw_read_zero_lat4 got=%h want=0", rdata4); end
    endtask

    task automatic test_bd_collision();
        logic [DATA_W-1:0] want;
        want         = ref_mem[9];
        want[7:0]    = 8'h5A;
        bd_we        = 1'b1;
        bd_addr      = AW'(9);
        bd_wdata     = {BYTES{8'h33}};
        av_write     = 1'b1;
        av_addr      = 32'(9 * BYTES);
        av_be        = 32'h0000_0001;
        av_wdata     = {BYTES{8'h5A}};
        tick();
        idle();
        tick();
        total++; if (bdr1 !== want) begin bad++; $display("FAIL bd_collision got=%h want=%h", bdr1, want); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            av_addr  = rand_addr();
            av_read  = ($urandom_range(0, 9) < 5);
            av_write = ($urandom_range(0, 9) < 3);
            av_be    = ($urandom_range(0, 7) == 0) ? '0 : BYTES'({$urandom(), $urandom()});
            av_wdata = rand_word();
            bd_we    = ($urandom_range(0, 9) < 2);
            bd_addr  = ($urandom_range(0, 3) == 0) ? AW'((av_addr - BASE) / BYTES) : AW'($urandom());
            bd_wdata = rand_word();
            tick();
            total++; if (rdata1 !== exp_rd(1)) begin
                bad++; $display("FAIL rand_rdata1 n=%0d got=%h want=%h", n, rdata1, exp_rd(1));
            end
            total++; if (rdata4 !== exp_rd(4)) begin
                bad++; $display("FAIL rand_rdata4 n=%0d got=%h want=%h", n, rdata4, exp_rd(4));
            end
            total++; if (bdr1 !== ref_bd || bdr4 !== ref_bd) begin
                bad++; $display("FAIL rand_bd_rdata n=%0d got=%h want=%h", n, bdr1, ref_bd);
            end
            total++; if (rdc1 !== ref_rd || wrc1 !== ref_wr || errc1 !== 16'(ref_err) ||
                         rdc4 !== ref_rd || wrc4 !== ref_wr || errc4 !== 16'(ref_err)) begin
                bad++; $display("FAIL rand_counters n=%0d got rd=%0d wr=%0d err=%0d want rd=%0d wr=%0d err=%0d",
                                n, rdc1, wrc1, errc1, ref_rd, ref_wr, ref_err);
            end
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 3; i++) begin
            av_read = 1'b1;
            av_addr = 32'((10 + i) * BYTES);
            tick();
        end
        idle();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++; if (rdata4 !== '0) begin bad++; $display("FAIL inflight_async_clear got=%h want=0", rdata4); end
        repeat (2) tick();
        reset   = 1'b0;
        bd_addr = AW'(3);
        for (int k = 0; k < 6; k++) begin
            tick();
            total++; if (rdata4 !== '0 || rdata1 !== '0) begin
                bad++; $display("FAIL inflight_no_return k=%0d got=%h want=0", k, rdata4);
            end
        end
        total++; if ({rdc4, wrc4, errc4} !== '0) begin
            bad++; $display("FAIL inflight_counters got rd=%0d wr=%0d err=%0d want 0", rdc4, wrc4, errc4);
        end
        total++; if (bdr4 !== ref_mem[3]) begin
            bad++; $display("FAIL inflight_mem_kept got=%h want=%h", bdr4, ref_mem[3]);
        end
    endtask

    initial begin
        test_reset();
        test_backdoor_read_seq();
        test_byteenable();
        test_errors();
        test_latency4();
        test_raw_illegal();
        test_bd_collision();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
